// File: rtl/arrow_spawn_scheduler_if.sv
// Signals between the attack-phase scheduler and its environment:
// game-state control, pattern ROM fetch, arrow slot launch/retire, and damage status.
interface arrow_spawn_scheduler_if #(
  parameter int NUM_SLOTS  = 8,
  parameter int MAX_EVENTS = 24,
  parameter int AW         = (MAX_EVENTS > 1) ? $clog2(MAX_EVENTS) : 1
);
  logic                 start;
  logic                 abort;
  logic [AW-1:0]        evt_addr;
  logic [7:0]           evt_data;
  logic [NUM_SLOTS-1:0] spawn_valid;
  logic [1:0]           spawn_dir;
  logic [1:0]           spawn_speed;
  logic                 spawn_inv;
  logic [NUM_SLOTS-1:0] retire_in;
  logic [NUM_SLOTS-1:0] hit_player_in;
  logic [NUM_SLOTS-1:0] active;
  logic                 busy;
  logic                 finished;
  logic                 damage_out;
  logic [7:0]           damage_count;

  modport master (
    input  start, abort, evt_data, retire_in, hit_player_in,
    output evt_addr, spawn_valid, spawn_dir, spawn_speed, spawn_inv,
           active, busy, finished, damage_out, damage_count
  );

  modport slave (
    output start, abort, evt_data, retire_in, hit_player_in,
    input  evt_addr, spawn_valid, spawn_dir, spawn_speed, spawn_inv,
           active, busy, finished, damage_out, damage_count
  );
endinterface

// File: rtl/arrow_spawn_scheduler.sv
// Attack-phase scheduler: walks the spawn pattern, waits each event's delay,
// launches into the lowest free arrow slot, tracks in-flight slots and player damage.
module arrow_spawn_scheduler #(
  parameter int NUM_SLOTS  = 8,
  parameter int MAX_EVENTS = 24,
  parameter int TICK_DIV   = 32500000
) (
  input logic clk,
  input logic rst,
  arrow_spawn_scheduler_if.master bus
);
  localparam int AW = (MAX_EVENTS > 1) ? $clog2(MAX_EVENTS) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(MAX_EVENTS - 1);
  localparam logic [31:0]   TICK      = 32'(TICK_DIV);

  // IDLE wait start | FETCH drive evt_addr | LOAD latch event | WAIT count delay
  // ALLOC launch into lowest free slot | DRAIN wait for all retires | DONE finish pulse
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_ALLOC, S_DRAIN, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        addr_q;
  logic [1:0]           delay_q, dir_q, speed_q;
  logic                 inv_q, last_q;
  logic [31:0]          tick_q, tick_end;
  logic [NUM_SLOTS-1:0] active_q, free_onehot, spawn_mask;
  logic                 free_found, spawn_fire;
  logic                 phase_start, phase_abort, hit_any;
  logic                 dmg_out_q;
  logic [7:0]           dmg_cnt_q;

  assign phase_start = (state_q == S_IDLE) && bus.start;
  assign phase_abort = (state_q != S_IDLE) && bus.abort;
  assign hit_any     = |(bus.hit_player_in & active_q);
  assign tick_end    = {30'd0, delay_q} * TICK - 32'd1;

  always_comb begin
    free_found  = 1'b0;
    free_onehot = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!free_found && !active_q[i]) begin
        free_found     = 1'b1;
        free_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    spawn_fire = 1'b0;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = (bus.evt_data[1:0] == 2'd0) ? S_ALLOC : S_WAIT;
      S_WAIT:  if (tick_q == tick_end) state_d = S_ALLOC;
      S_ALLOC: begin
        // With every slot in flight the event stalls here until a retire frees one.
        if (free_found) begin
          spawn_fire = 1'b1;
          state_d    = (last_q || addr_q == LAST_ADDR) ? S_DRAIN : S_FETCH;
        end
      end
      S_DRAIN: if (active_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (phase_abort) state_d = S_IDLE;
  end

  assign spawn_mask = spawn_fire ? free_onehot : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      delay_q   <= '0;
      dir_q     <= '0;
      speed_q   <= '0;
      inv_q     <= 1'b0;
      last_q    <= 1'b0;
      tick_q    <= '0;
      active_q  <= '0;
      dmg_out_q <= 1'b0;
      dmg_cnt_q <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == S_LOAD) begin
        delay_q <= bus.evt_data[1:0];
        dir_q   <= bus.evt_data[3:2];
        speed_q <= bus.evt_data[5:4];
        inv_q   <= bus.evt_data[6];
        last_q  <= bus.evt_data[7];
        tick_q  <= '0;
      end else if (state_q == S_WAIT) begin
        tick_q <= tick_q + 32'd1;
      end

      if (state_d == S_IDLE) addr_q <= '0;
      else if (spawn_fire && state_d == S_FETCH) addr_q <= addr_q + AW'(1);

      if (phase_start || phase_abort) active_q <= '0;
      else active_q <= (active_q & ~bus.retire_in) | spawn_mask;

      dmg_out_q <= hit_any;
      if (phase_start) dmg_cnt_q <= '0;
      else if (hit_any && dmg_cnt_q != 8'hFF) dmg_cnt_q <= dmg_cnt_q + 8'd1;
    end
  end

  assign bus.evt_addr     = addr_q;
  assign bus.spawn_valid  = spawn_mask;
  assign bus.spawn_dir    = spawn_fire ? dir_q : 2'b00;
  assign bus.spawn_speed  = spawn_fire ? speed_q : 2'b00;
  assign bus.spawn_inv    = spawn_fire & inv_q;
  assign bus.active       = active_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.finished     = (state_q == S_DONE);
  assign bus.damage_out   = dmg_out_q;
  assign bus.damage_count = dmg_cnt_q;
endmodule

// File: doc/arrow_spawn_scheduler.md
# arrow_spawn_scheduler

Sequences one enemy attack phase: walks a pattern of spawn events, waits the programmed delay for each, and assigns every event to a free arrow slot from a fixed pool. It tracks which slots are in flight, retires them on hit or block, and counts player damage. It reports phase completion once the last event is spawned and every slot has retired. It sits between the game-state FSM and the arrow instances, in place of hard-wired per-arrow launch logic.

## Interface
- NUM_SLOTS, 8: arrow instances in the pool (1..16).
- MAX_EVENTS, 24: pattern length cap; event address width AW = $clog2(MAX_EVENTS).
- TICK_DIV, 32500000: clk cycles per delay unit (0.5 s at 65 MHz).
- clk  in  1  clock.
- rst  in  1  reset rst, synchronous, active-high.
- start  in  1  pulse; begins a phase (state FSM entering attack).
- abort  in  1  level; ends the phase immediately.
- evt_addr  out  AW  pattern event index.
- evt_data  in  8  {last, inversed, speed[1:0], direction[1:0], delay[1:0]}; valid 1 cycle after evt_addr.
- spawn_valid  out  NUM_SLOTS  one-hot one-cycle launch pulse to slot.
- spawn_dir  out  2  direction for the launched arrow.
- spawn_speed  out  2  speed for the launched arrow.
- spawn_inv  out  1  inversed flag for the launched arrow.
- retire_in  in  NUM_SLOTS  per-slot pulse: arrow hit shield or player.
- hit_player_in  in  NUM_SLOTS  per-slot pulse: arrow hit player (accompanies retire_in).
- active  out  NUM_SLOTS  slots in flight.
- busy  out  1  high from the cycle after start until finished or abort.
- finished  out  1  one-cycle completion pulse.
- damage_out  out  1  one-cycle pulse per cycle with any counted hit.
- damage_count  out  8  hits this phase, saturating at 255.

## Operation
- States: IDLE, FETCH, LOAD, WAIT, ALLOC, DRAIN, DONE.
- IDLE: evt_addr=0. start -> FETCH; clear damage_count and active.
- FETCH: drive evt_addr for one cycle -> LOAD.
- LOAD: latch evt_data fields and clear the tick counter. delay==0 -> ALLOC; otherwise -> WAIT.
- WAIT: 32-bit counter increments each cycle. At delay*TICK_DIV-1 -> ALLOC.
- ALLOC: pick the lowest-index slot with active==0.
  - If one exists: pulse its spawn_valid bit, drive dir/speed/inv from the latched fields, and set active for that slot.
  - Then, if last==1 or evt_addr==MAX_EVENTS-1, go to DRAIN; otherwise evt_addr+1 and FETCH.
  - No free slot: stay in ALLOC (stall); spawn outputs stay 0.
- DRAIN: active==0 -> DONE.
- DONE: finished=1 for one cycle -> IDLE.
- Retire: active &= ~retire_in each cycle. Bits for inactive slots are ignored.
- Damage: if (hit_player_in & active)!=0, damage_out=1 the next cycle and damage_count increments by 1 per cycle (not per bit), saturating.
- start while busy: ignored. abort (any non-IDLE state): next state IDLE, active cleared, no finished pulse; damage_count holds.

## Timing
- Reset: all outputs 0, state IDLE, damage_count 0.
- Spawn cadence: ALLOC cycle = LOAD cycle + delay*TICK_DIV + 1. Consecutive unstalled events are 3+delay*TICK_DIV cycles apart.
- The active mask is registered. A slot retired in cycle N is allocatable from cycle N+1.
- Retire and spawn in the same cycle on different slots are both applied.
- ALLOC in the same cycle as DRAIN-ready is impossible: DRAIN is entered only after the last spawn.
- An empty pattern does not exist: event 0 is always spawned.
- First spawn with delay 0: ALLOC at start+3.

## Test plan
- TICK_DIV=4, delays 1,1,1, last on event 2, start at cycle 0 -> spawn_valid 0x01@7, 0x02@14, 0x04@21; retire all at 30 -> finished@32, busy low@32+1.
- NUM_SLOTS=2, three delay-0 events, no retires -> two spawns then ALLOC stall. retire_in=0x01 at cycle T -> third spawn on slot 0 at T+1.
- hit_player_in=0x03 with retire_in=0x03 at the same cycle, both active -> damage_out one pulse, damage_count+1. Hit on an inactive slot -> no pulse.
- 256 counted hit cycles -> damage_count=255.
- Pattern without a last flag, MAX_EVENTS=4 -> exactly 4 spawns, evt_addr stops at 3, then DRAIN.
- abort during WAIT -> IDLE next cycle, active=0, finished never pulses. start during busy -> no effect. rst mid-WAIT -> all outputs 0 next cycle.
